acc_requant: RTL and testbench

- Output-side counterpart of the pipelined MAC datapath.
- Consumes signed ACCUM_WIDTH accumulator results and requantizes them to signed OUT_WIDTH activations for the next layer or the writeback buffer, in the reverse direction of the MAC's 8-bit-to-24-bit widening.
- Processing per beat: fixed-point scale multiply, round-half-up arithmetic right shift, zero-point add, optional ReLU, saturation.
- 3-stage pipeline with valid/ready handshake on both sides and a saturation event counter.

---
 rtl/acc_requant.sv | 79 +++++++
 tb/tb_acc_requant.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/acc_requant.sv
// acc_requant: requantize signed accumulators to signed activations (scale, round-shift, zero point, ReLU, saturate)
module acc_requant #(
  parameter int ACCUM_WIDTH = 24,
  parameter int OUT_WIDTH   = 8,
  parameter int SCALE_WIDTH = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ACCUM_WIDTH-1:0] in_acc,
  input  logic [SCALE_WIDTH-1:0] scale,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic [OUT_WIDTH-1:0]   zero_point,
  input  logic                   relu_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   sat_flag,
  output logic [CNT_WIDTH-1:0]   sat_count,
  input  logic                   clear_count
);
  localparam int P = ACCUM_WIDTH + SCALE_WIDTH + 1;
  localparam logic signed [P-1:0] ZMAX = P'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [P-1:0] ZMIN = ~ZMAX;
  logic v1, v2, v3, adv;
  logic signed [P-1:0] p1, z2, r_c, z_c, za;
  logic [P-1:0] rnd;
  logic [SHIFT_WIDTH-1:0] s1;
  logic [OUT_WIDTH-1:0] zp1, zp2, o_c;
  logic re1, re2, rn2, hi, lo;
  assign adv = !v3 || out_ready;
  assign in_ready = adv;
  assign out_valid = v3;
  always_comb begin
    rnd = (s1 == '0) ? '0 : P'(1) << (s1 - 1'b1);
    r_c = $signed(p1 + rnd) >>> s1;
    z_c = r_c + P'($signed(zp1));
    za = (re2 && rn2) ? P'($signed(zp2)) : z2;
    hi = za > ZMAX;
    lo = za < ZMIN;
    o_c = hi ? ZMAX[OUT_WIDTH-1:0] : lo ? ZMIN[OUT_WIDTH-1:0] : za[OUT_WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {v1, v2, v3} <= '0;
      p1 <= '0;
      s1 <= '0;
      zp1 <= '0;
      re1 <= 1'b0;
      z2 <= '0;
      rn2 <= 1'b0;
      zp2 <= '0;
      re2 <= 1'b0;
      out_data <= '0;
      sat_flag <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      p1 <= P'($signed(in_acc)) * P'($signed({1'b0, scale}));
      s1 <= shift;
      zp1 <= zero_point;
      re1 <= relu_en;
      v2 <= v1;
      z2 <= z_c;
      rn2 <= r_c[P-1];
      zp2 <= zp1;
      re2 <= re1;
      v3 <= v2;
      out_data <= o_c;
      sat_flag <= hi | lo;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || clear_count) sat_count <= '0;
    else if (v3 && out_ready && sat_flag && !(&sat_count)) sat_count <= sat_count + 1'b1;
  end
endmodule

// File: tb/tb_acc_requant.sv
// tb_acc_requant: directed self-checking bench for acc_requant
module tb_acc_requant;
  logic clk = 1'b0, rst, in_valid, in_ready, relu_en, out_valid, out_ready, sat_flag, clear_count;
  logic [23:0] in_acc;
  logic [15:0] scale, sat_count;
  logic [4:0] shift;
  logic [7:0] zero_point, out_data;
  int vec = 0, err = 0;
  always #5 clk = ~clk;
  acc_requant dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
    .scale(scale), .shift(shift), .zero_point(zero_point), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_flag(sat_flag), .sat_count(sat_count), .clear_count(clear_count)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_cfg(input logic [15:0] sc, input logic [4:0] sh, input logic [7:0] zp, input logic re);
    scale = sc;
    shift = sh;
    zero_point = zp;
    relu_en = re;
  endtask
  // One beat with out_ready high: checks latency, data and flag, then lets it transfer.
  task automatic run1(input string nm, input logic [23:0] a, input logic [15:0] sc, input logic [4:0] sh,
                      input logic [7:0] zp, input logic re, input logic [7:0] ed, input logic es);
    out_ready = 1'b1;
    set_cfg(sc, sh, zp, re);
    in_acc = a;
    in_valid = 1'b1;
    vec++;
    if (in_ready !== 1'b1) begin err++; $display("FAIL %s in_ready: got %b want 1", nm, in_ready); end
    tick;
    in_valid = 1'b0;
    set_cfg(16'hffff, 5'd3, 8'h55, 1'b1);
    for (int i = 0; i < 2; i++) begin
      vec++;
      if (out_valid !== 1'b0) begin err++; $display("FAIL %s early out_valid at %0d: got %b want 0", nm, i + 1, out_valid); end
      tick;
    end
    vec++;
    if (out_valid !== 1'b1 || out_data !== ed || sat_flag !== es) begin
      err++;
      $display("FAIL %s: got v=%b d=%0d s=%b want v=1 d=%0d s=%b", nm, out_valid, $signed(out_data), sat_flag, $signed(ed), es);
    end
    tick;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    clear_count = 1'b0;
    in_acc = '0;
    set_cfg(16'd0, 5'd0, 8'd0, 1'b0);
    repeat (2) tick;
    vec++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || sat_flag !== 1'b0 || sat_count !== 16'd0 || in_ready !== 1'b1) begin
      err++;
      $display("FAIL reset: got v=%b d=%h s=%b c=%0d r=%b want 0 0 0 0 1", out_valid, out_data, sat_flag, sat_count, in_ready);
    end
    rst = 1'b0;
  endtask
  task automatic test_basic;
    run1("basic", 24'd100, 16'd16384, 5'd15, 8'd0, 1'b0, 8'd50, 1'b0);
  endtask
  task automatic test_rounding;
    run1("round_p3", 24'd3, 16'd1, 5'd1, 8'd0, 1'b0, 8'd2, 1'b0);
    run1("round_m3", -24'sd3, 16'd1, 5'd1, 8'd0, 1'b0, -8'sd1, 1'b0);
    run1("round_m4", -24'sd4, 16'd1, 5'd1, 8'd0, 1'b0, -8'sd2, 1'b0);
    run1("round_sh0", 24'd5, 16'd1, 5'd0, 8'd0, 1'b0, 8'd5, 1'b0);
  endtask
  task automatic test_saturation;
    run1("sat_hi", 24'd1000, 16'd1, 5'd0, 8'd0, 1'b0, 8'd127, 1'b1);
    run1("sat_lo", -24'sd1000, 16'd1, 5'd0, 8'd0, 1'b0, -8'sd128, 1'b1);
    vec++;
    if (sat_count !== 16'd2) begin err++; $display("FAIL sat_count: got %0d want 2", sat_count); end
    set_cfg(16'd1, 5'd0, 8'd0, 1'b0);
    in_acc = 24'd1000;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    clear_count = 1'b1;
    vec++;
    if (out_valid !== 1'b1 || sat_flag !== 1'b1) begin err++; $display("FAIL clear_setup: got v=%b s=%b want 1 1", out_valid, sat_flag); end
    tick;
    clear_count = 1'b0;
    vec++;
    if (sat_count !== 16'd0) begin err++; $display("FAIL clear_wins: got %0d want 0", sat_count); end
  endtask
  task automatic test_relu;
    run1("relu_on", -24'sd50, 16'd1, 5'd0, 8'd10, 1'b1, 8'd10, 1'b0);
    run1("relu_off", -24'sd50, 16'd1, 5'd0, 8'd10, 1'b0, -8'sd40, 1'b0);
    run1("zp_sat", 24'd200, 16'd1, 5'd0, -8'sd10, 1'b0, 8'd127, 1'b1);
    vec++;
    if (sat_count !== 16'd1) begin err++; $display("FAIL relu_count: got %0d want 1", sat_count); end
  endtask
  task automatic test_back_to_back;
    int sent = 0, got = 0;
    logic acc, xf, stall = 1'b0;
    logic [7:0] prev = '0, d;
    set_cfg(16'd1, 5'd0, 8'd0, 1'b0);
    for (int c = 0; c < 40 && got < 8; c++) begin
      out_ready = !(c >= 4 && c <= 7);
      in_valid = sent < 8;
      in_acc = 24'(sent + 1);
      #1;
      vec++;
      if (in_ready !== !(out_valid && !out_ready)) begin err++; $display("FAIL bp_ready c=%0d: got %b want %b", c, in_ready, !(out_valid && !out_ready)); end
      if (c == 5) begin
        vec++;
        if (in_ready !== 1'b0) begin err++; $display("FAIL bp_stall_ready: got %b want 0", in_ready); end
      end
      if (stall) begin
        vec++;
        if (out_valid !== 1'b1 || out_data !== prev) begin err++; $display("FAIL bp_stable c=%0d: got v=%b d=%0d want v=1 d=%0d", c, out_valid, out_data, prev); end
      end
      acc = in_valid && in_ready;
      xf = out_valid && out_ready;
      stall = out_valid && !out_ready;
      prev = out_data;
      d = out_data;
      @(posedge clk);
      if (acc) sent++;
      if (xf) begin
        vec++;
        if (d !== 8'(got + 1)) begin err++; $display("FAIL bp_order #%0d: got %0d want %0d", got, d, got + 1); end
        got++;
      end
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    vec++;
    if (got !== 8 || sent !== 8) begin err++; $display("FAIL bp_count: got out=%0d in=%0d want 8 8", got, sent); end
  endtask
  task automatic test_reset_midstream;
    set_cfg(16'd1, 5'd0, 8'd0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_acc = 24'(7 + i);
      in_valid = 1'b1;
      tick;
    end
    in_valid = 1'b0;
    vec++;
    if (out_valid !== 1'b1 || out_data !== 8'd7 || sat_count !== 16'd1) begin
      err++;
      $display("FAIL mid_prefill: got v=%b d=%0d c=%0d want 1 7 1", out_valid, out_data, sat_count);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    vec++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || sat_count !== 16'd0) begin
      err++;
      $display("FAIL mid_reset: got v=%b d=%0d c=%0d want 0 0 0", out_valid, out_data, sat_count);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      vec++;
      if (out_valid !== 1'b0) begin err++; $display("FAIL mid_stale %0d: got %b want 0", i, out_valid); end
    end
    run1("mid_new", 24'd42, 16'd1, 5'd0, 8'd0, 1'b0, 8'd42, 1'b0);
  endtask
  initial begin
    test_reset;
    test_basic;
    test_rounding;
    test_saturation;
    test_relu;
    test_back_to_back;
    test_reset_midstream;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
